// File: rtl/dma_reg_sequencer_if.sv
// Control/status bundle for dma_reg_sequencer.
//   master : drives the programming port and the run controls, observes status
//   slave  : the sequencer side
// Signals
//   prog_we/prog_addr/prog_data : table write port, entry = {delay, reg_sel, mask, value}
//   num_steps, loop_en, start, abort : run controls
//   busy, done, step_idx, sel_err    : run status
interface dma_reg_sequencer_if #(
    parameter int REG_W   = 16,
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 16,
    parameter int SEL_W   = 4,
    parameter int IDX_W   = $clog2(DEPTH)
);
    logic                             prog_we;
    logic [IDX_W-1:0]                 prog_addr;
    logic [DELAY_W+SEL_W+2*REG_W-1:0] prog_data;
    logic [IDX_W:0]                   num_steps;
    logic                             loop_en;
    logic                             start;
    logic                             abort;
    logic                             busy;
    logic                             done;
    logic [IDX_W-1:0]                 step_idx;
    logic                             sel_err;

    modport master (
        output prog_we, prog_addr, prog_data, num_steps, loop_en, start, abort,
        input  busy, done, step_idx, sel_err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, num_steps, loop_en, start, abort,
        output busy, done, step_idx, sel_err
    );
endinterface

// File: rtl/dma_reg_sequencer.sv
// Programmable register-stimulus sequencer for the ADMA/SD host.
// Replays a run-time table of timed masked writes onto NUM_REGS host registers,
// pulsing a one-hot write strobe with every applied write.
// Ports
//   CLK, RESET  : rising-edge clock, synchronous active-high reset
//   bus         : dma_reg_sequencer_if.slave (table port, run controls, status)
//   regs_out    : register i at [i*REG_W +: REG_W]
//   reg_wr_stb  : one-cycle one-hot strobe, same edge as the register update
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | counting down the pending entry delay, applying entries
// DONE    | sequence complete, waiting for start to drop
module dma_reg_sequencer #(
    parameter int REG_W    = 16,
    parameter int NUM_REGS = 9,
    parameter int DEPTH    = 16,
    parameter int DELAY_W  = 16,
    parameter int SEL_W    = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    dma_reg_sequencer_if.slave         bus,
    output logic [NUM_REGS*REG_W-1:0]  regs_out,
    output logic [NUM_REGS-1:0]        reg_wr_stb
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OP_W  = SEL_W + 2*REG_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [DELAY_W-1:0] cnt;
    logic [IDX_W:0]     num_lat;
    logic [IDX_W-1:0]   step_idx_q;
    logic               sel_err_q;
    logic [REG_W-1:0]   regs [NUM_REGS];

    // Delays live apart from the write operation so the next-delay lookup and
    // the current-entry decode each read a whole word.
    logic [DELAY_W-1:0] dly_tbl [DEPTH];
    logic [OP_W-1:0]    op_tbl  [DEPTH];

    logic [OP_W-1:0]    cur_op;
    logic [SEL_W-1:0]   cur_sel;
    logic [REG_W-1:0]   cur_mask;
    logic [REG_W-1:0]   cur_val;
    logic               sel_ok;
    logic               is_last;
    logic [IDX_W-1:0]   next_idx;
    logic [IDX_W:0]     num_eff;
    logic               busy_int;

    assign busy_int = (state == ST_RUN);

    // Table has no reset so a programmed sequence survives a host reset.
    always_ff @(posedge CLK) begin
        if (bus.prog_we && !busy_int) begin
            dly_tbl[bus.prog_addr] <= bus.prog_data[OP_W +: DELAY_W];
            op_tbl[bus.prog_addr]  <= bus.prog_data[OP_W-1:0];
        end
    end

    assign cur_op   = op_tbl[step_idx_q];
    assign cur_sel  = cur_op[2*REG_W +: SEL_W];
    assign cur_mask = cur_op[REG_W +: REG_W];
    assign cur_val  = cur_op[0 +: REG_W];
    assign sel_ok   = ({1'b0, cur_sel} < (SEL_W+1)'(NUM_REGS));
    assign is_last  = ({1'b0, step_idx_q} == (num_lat - 1'b1));
    assign next_idx = step_idx_q + 1'b1;
    // Counts beyond the table depth run the whole table rather than wrapping.
    assign num_eff  = (bus.num_steps > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : bus.num_steps;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            num_lat    <= '0;
            step_idx_q <= '0;
            sel_err_q  <= 1'b0;
            reg_wr_stb <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            reg_wr_stb <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (num_eff != '0) begin
                            state      <= ST_RUN;
                            step_idx_q <= '0;
                            cnt        <= dly_tbl[0];
                            num_lat    <= num_eff;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (sel_ok && (cur_sel == SEL_W'(i))) begin
                                regs[i]       <= (regs[i] & ~cur_mask) | (cur_val & cur_mask);
                                reg_wr_stb[i] <= 1'b1;
                            end
                        end
                        if (!sel_ok) sel_err_q <= 1'b1;
                        if (!is_last) begin
                            step_idx_q <= next_idx;
                            cnt        <= dly_tbl[next_idx];
                        end else if (bus.loop_en) begin
                            step_idx_q <= '0;
                            cnt        <= dly_tbl[0];
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.start) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs_out[g*REG_W +: REG_W] = regs[g];
    end

    assign bus.busy     = busy_int;
    assign bus.done     = (state == ST_DONE);
    assign bus.step_idx = step_idx_q;
    assign bus.sel_err  = sel_err_q;
endmodule

// File: tb/tb_dma_reg_sequencer.sv
module tb_dma_reg_sequencer;
    localparam int REG_W    = 16;
    localparam int NUM_REGS = 9;
    localparam int DEPTH    = 16;
    localparam int DELAY_W  = 16;
    localparam int SEL_W    = 4;
    localparam int IDX_W    = 4;
    localparam int ENTRY_W  = DELAY_W + SEL_W + 2*REG_W;

    logic                      CLK = 1'b0;
    logic                      RESET;
    logic [NUM_REGS*REG_W-1:0] regs_out;
    logic [NUM_REGS-1:0]       reg_wr_stb;

    dma_reg_sequencer_if #(.REG_W(REG_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .SEL_W(SEL_W), .IDX_W(IDX_W)) bus_if();

    dma_reg_sequencer #(.REG_W(REG_W), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .SEL_W(SEL_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus_if),
        .regs_out   (regs_out),
        .reg_wr_stb (reg_wr_stb)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: table contents, register file, sticky error
    int          m_delay [DEPTH];
    int          m_sel   [DEPTH];
    logic [15:0] m_mask  [DEPTH];
    logic [15:0] m_val   [DEPTH];
    logic [15:0] m_regs  [NUM_REGS];
    bit          m_sel_err;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] model_bus();
        logic [159:0] b = '0;
        for (int i = 0; i < NUM_REGS; i++) b[i*REG_W +: REG_W] = m_regs[i];
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_sel_err = 1'b0;
    endtask

    task automatic prog_entry(input int idx, input int dly, input int sel,
                              input logic [15:0] mask, input logic [15:0] val);
        bus_if.prog_we   = 1'b1;
        bus_if.prog_addr = IDX_W'(idx);
        bus_if.prog_data = {DELAY_W'(dly), SEL_W'(sel), mask, val};
        @(posedge CLK); #1;
        bus_if.prog_we = 1'b0;
        m_delay[idx] = dly;
        m_sel[idx]   = sel;
        m_mask[idx]  = mask;
        m_val[idx]   = val;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_regs"}, 160'(regs_out), '0);
        chk({tag, "_stb"}, 160'(reg_wr_stb), '0);
        chk({tag, "_busy"}, 160'(bus_if.busy), '0);
        chk({tag, "_done"}, 160'(bus_if.done), '0);
        chk({tag, "_idx"}, 160'(bus_if.step_idx), '0);
        chk({tag, "_selerr"}, 160'(bus_if.sel_err), '0);
    endtask

    // Write k lands delay_k+1 edges after the previous one (or after the start
    // edge E0). Every edge after E0 is compared against that timeline.
    task automatic run_seq(input int n, input bit loop, input int abort_at,
                           input bit hold, input bit poke);
        int ev_t[$];
        int ev_k[$];
        int t, k, t_last, n_cyc;
        logic [NUM_REGS-1:0] exp_stb;
        bit exp_busy, exp_done;
        t = 0; k = 0; t_last = 0;
        if (n > 0) begin
            forever begin
                t += m_delay[k] + 1;
                if (abort_at > 0 && t >= abort_at) break;
                ev_t.push_back(t);
                ev_k.push_back(k);
                if (k == n - 1) begin
                    if (!loop) begin t_last = t; break; end
                    k = 0;
                end else begin
                    k++;
                end
            end
        end
        n_cyc = (abort_at > 0) ? abort_at + 6 : t_last + (hold ? 5 : 3);

        bus_if.num_steps = (IDX_W+1)'(n);
        bus_if.loop_en   = loop;
        bus_if.start     = 1'b1;
        @(posedge CLK); #1;
        if (!hold) bus_if.start = 1'b0;

        for (int cyc = 0; cyc < n_cyc; cyc++) begin
            exp_stb = '0;
            for (int e = 0; e < ev_t.size(); e++) begin
                if (ev_t[e] == cyc) begin
                    int s;
                    s = m_sel[ev_k[e]];
                    if (s < NUM_REGS) begin
                        m_regs[s] = (m_regs[s] & ~m_mask[ev_k[e]]) | (m_val[ev_k[e]] & m_mask[ev_k[e]]);
                        exp_stb[s] = 1'b1;
                    end else begin
                        m_sel_err = 1'b1;
                    end
                end
            end
            if (abort_at > 0) begin
                exp_busy = (cyc < abort_at);
                exp_done = 1'b0;
            end else begin
                exp_busy = (cyc < t_last);
                exp_done = hold ? (cyc >= t_last && cyc < t_last + 3) : (cyc == t_last);
            end
            chk($sformatf("stb@%0d", cyc), 160'(reg_wr_stb), 160'(exp_stb));
            chk($sformatf("regs@%0d", cyc), 160'(regs_out), model_bus());
            chk($sformatf("busy@%0d", cyc), 160'(bus_if.busy), 160'(exp_busy));
            chk($sformatf("done@%0d", cyc), 160'(bus_if.done), 160'(exp_done));
            chk($sformatf("selerr@%0d", cyc), 160'(bus_if.sel_err), 160'(m_sel_err));

            if (hold && cyc == t_last + 2) bus_if.start = 1'b0;
            if (abort_at > 0 && cyc == abort_at - 1) bus_if.abort = 1'b1;
            if (abort_at > 0 && cyc == abort_at) bus_if.abort = 1'b0;
            if (poke && cyc == 0) begin
                bus_if.prog_we   = 1'b1;
                bus_if.prog_addr = IDX_W'($urandom_range(0, DEPTH - 1));
                bus_if.prog_data = ENTRY_W'({$urandom(), $urandom()});
            end
            if (poke && cyc == 1) bus_if.prog_we = 1'b0;
            @(posedge CLK); #1;
        end
        bus_if.abort   = 1'b0;
        bus_if.prog_we = 1'b0;
        if (n > 0 && abort_at == 0) chk("step_idx_end", 160'(bus_if.step_idx), 160'(n - 1));
    endtask

    initial begin
        RESET            = 1'b1;
        bus_if.prog_we   = 1'b0;
        bus_if.prog_addr = '0;
        bus_if.prog_data = '0;
        bus_if.num_steps = '0;
        bus_if.loop_en   = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.abort     = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        chk_reset("por");
        RESET = 1'b0;
        @(posedge CLK); #1;

        // reference flow: xfer[0]=1, cmd[7:6]=2, xfer[4]=1
        prog_entry(0, 0,  8, 16'h0001, 16'h0001);
        prog_entry(1, 1,  4, 16'h00C0, 16'h0080);
        prog_entry(2, 14, 8, 16'h0010, 16'h0010);
        run_seq(3, 1'b0, 0, 1'b0, 1'b0);
        chk("ref_cmd", 160'(regs_out[4*REG_W +: REG_W]), 160'(16'h0080));
        chk("ref_xfer", 160'(regs_out[8*REG_W +: REG_W]), 160'(16'h0011));

        // back-to-back writes, start held past completion
        for (int i = 0; i < 4; i++)
            prog_entry(i, 0, i, 16'hFFFF, 16'($urandom()));
        run_seq(4, 1'b0, 0, 1'b1, 1'b0);

        // loop with abort at edge 9
        prog_entry(0, 3, 0, 16'h00FF, 16'h005A);
        prog_entry(1, 3, 1, 16'hFF00, 16'hA500);
        run_seq(2, 1'b1, 9, 1'b0, 1'b0);

        // empty sequence, then writes attempted while busy, then replay
        run_seq(0, 1'b0, 0, 1'b0, 1'b0);
        prog_entry(0, 2, 5, 16'hFFFF, 16'h1234);
        prog_entry(1, 1, 6, 16'h0F0F, 16'hABCD);
        prog_entry(2, 0, 7, 16'h0000, 16'hFFFF);
        run_seq(3, 1'b0, 0, 1'b0, 1'b1);
        run_seq(3, 1'b0, 0, 1'b0, 1'b0);

        // reset in the middle of a run, then replay from entry 0
        for (int i = 0; i < 5; i++)
            prog_entry(i, $urandom_range(1, 3), $urandom_range(0, NUM_REGS - 1), 16'($urandom()), 16'($urandom()));
        bus_if.num_steps = 5'd5;
        bus_if.start     = 1'b1;
        @(posedge CLK); #1;
        bus_if.start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk_reset("midrun");
        model_clear();
        run_seq(5, 1'b0, 0, 1'b0, 1'b0);

        // out-of-range select in the middle of a sequence
        prog_entry(0, 1, 2, 16'hFFFF, 16'h1111);
        prog_entry(1, 0, 15, 16'hFFFF, 16'h2222);
        prog_entry(2, 2, 3, 16'hFFFF, 16'h3333);
        run_seq(3, 1'b0, 0, 1'b0, 1'b0);
        chk("selerr_sticky", 160'(bus_if.sel_err), 160'(1'b1));

        // randomized tables
        for (int r = 0; r < 6; r++) begin
            int n;
            for (int i = 0; i < DEPTH; i++)
                prog_entry(i, $urandom_range(0, 4), $urandom_range(0, NUM_REGS), 16'($urandom()), 16'($urandom()));
            n = $urandom_range(1, DEPTH);
            run_seq(n, 1'b0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
